// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, a one-entry hold buffer for
// decoder stalls, and flush/redirect. Define IF_PERF_CNT_EN to add the instCount counter.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemValid,
    input  logic [31:0] imemData,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirectPc,
    output logic [31:0] inst,
    output logic [31:0] instPc,
    output logic        instValid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] instCount
`endif
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DISCARD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        load_new;
    logic        unused_redirect_low;

    // Redirect targets are word aligned; the low bits are deliberately dropped.
    assign unused_redirect_low = ^redirectPc[1:0];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            unique case (state_q)
                ST_REQ:     state_d = imemGnt ? ST_DISCARD : ST_REQ;
                ST_WAIT:    state_d = imemValid ? ST_REQ : ST_DISCARD;
                ST_HOLD:    state_d = ST_REQ;
                ST_DISCARD: state_d = imemValid ? ST_REQ : ST_DISCARD;
                default:    state_d = ST_REQ;
            endcase
        end else begin
            unique case (state_q)
                ST_REQ:     if (imemGnt) state_d = ST_WAIT;
                ST_WAIT:    if (imemValid) state_d = stall ? ST_HOLD : ST_REQ;
                ST_HOLD:    if (!stall) state_d = ST_REQ;
                ST_DISCARD: if (imemValid) state_d = ST_REQ;
                default:    state_d = ST_REQ;
            endcase
        end
    end

    always_comb begin
        imemReq  = (state_q == ST_REQ);
        imemAddr = pc_q;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        hold_inst_d  = hold_inst_q;
        hold_pc_d    = hold_pc_q;
        load_new     = 1'b0;
        if (flush) begin
            pc_d         = {redirectPc[31:2], 2'b00};
            inst_d       = NOP_INST;
            inst_valid_d = 1'b0;
            hold_inst_d  = '0;
            hold_pc_d    = '0;
        end else begin
            if (state_q == ST_WAIT && imemValid) begin
                pc_d = pc_q + 32'd4;
                if (stall) begin
                    hold_inst_d = imemData;
                    hold_pc_d   = pc_q;
                end else begin
                    inst_d    = imemData;
                    inst_pc_d = pc_q;
                    load_new  = 1'b1;
                end
            end else if (state_q == ST_HOLD && !stall) begin
                inst_d    = hold_inst_q;
                inst_pc_d = hold_pc_q;
                load_new  = 1'b1;
            end
            if (load_new) begin
                inst_valid_d = 1'b1;
            end else if (!stall) begin
                inst_d       = NOP_INST;
                inst_valid_d = 1'b0;
            end
        end
    end

    // NOTE: the hold buffer is an ordinary register, so it is reset along with the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            inst_pc_q    <= RESET_PC;
            inst_valid_q <= 1'b0;
            hold_inst_q  <= '0;
            hold_pc_q    <= '0;
        end else begin
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            hold_inst_q  <= hold_inst_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    assign inst      = inst_q;
    assign instPc    = inst_pc_q;
    assign instValid = inst_valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] inst_count_q, inst_count_d;

    always_comb begin
        inst_count_d = load_new ? inst_count_q + 32'd1 : inst_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_count_q <= '0;
        end else begin
            inst_count_q <= inst_count_d;
        end
    end

    assign instCount = inst_count_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage: a transaction-level model (outstanding flag, drop flag,
// queue of held instructions) predicts every output; IF_PERF_CNT_EN also checks instCount.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imemReq, imemGnt, imemValid, stall, flush, instValid;
    logic [31:0] imemAddr, imemData, redirectPc, inst, instPc;
`ifdef IF_PERF_CNT_EN
    logic [31:0] instCount;
`endif

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt),
        .imemValid(imemValid), .imemData(imemData),
        .stall(stall), .flush(flush), .redirectPc(redirectPc),
        .inst(inst), .instPc(instPc), .instValid(instValid)
`ifdef IF_PERF_CNT_EN
        , .instCount(instCount)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } fetched_t;

    // Reference model
    logic [31:0] m_pc, m_inst, m_inst_pc, m_count;
    logic        m_valid, m_out, m_drop;
    fetched_t    m_held[$];

    // Memory model
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_data;
    int          lat_min = 1, lat_max = 1, gnt_pct = 100, spur_pct = 0;
    logic        fixed_en = 1'b0;
    logic [31:0] fixed_data = '0;

    task automatic model_reset();
        m_pc = RESET_PC; m_inst = NOP; m_inst_pc = RESET_PC; m_count = '0;
        m_valid = 1'b0; m_out = 1'b0; m_drop = 1'b0;
        m_held.delete();
    endtask

    task automatic mem_age();
        if (mem_busy) begin
            if (mem_cnt == 0) mem_busy = 1'b0;
            else mem_cnt--;
        end
    endtask

    task automatic model_edge(input logic accept);
        logic     resp, loaded;
        fetched_t h;
        resp   = m_out && imemValid;
        loaded = 1'b0;
        if (flush) begin
            m_pc = {redirectPc[31:2], 2'b00};
            m_inst = NOP; m_valid = 1'b0;
            m_held.delete();
            if (accept) begin m_out = 1'b1; m_drop = 1'b1; end
            else if (m_out) begin
                if (resp) begin m_out = 1'b0; m_drop = 1'b0; end
                else m_drop = 1'b1;
            end
        end else begin
            if (resp) begin
                m_out = 1'b0;
                if (m_drop) m_drop = 1'b0;
                else begin
                    if (!stall) begin m_inst = imemData; m_inst_pc = m_pc; loaded = 1'b1; end
                    else m_held.push_back('{data: imemData, pc: m_pc});
                    m_pc = m_pc + 32'd4;
                end
            end else if (m_held.size() != 0 && !stall) begin
                h = m_held.pop_front();
                m_inst = h.data; m_inst_pc = h.pc; loaded = 1'b1;
            end
            if (accept) begin m_out = 1'b1; m_drop = 1'b0; end
            if (loaded) begin m_valid = 1'b1; m_count = m_count + 32'd1; end
            else if (!stall) begin m_inst = NOP; m_valid = 1'b0; end
        end
    endtask

    // One clock: drive at the negedge, compare request outputs, step model and memory at the
    // posedge, then compare the registered outputs at the following negedge.
    task automatic cycle(input logic s, input logic f, input logic [31:0] rp);
        logic req_exp, dut_accept;
        stall = s; flush = f; redirectPc = rp;
        imemGnt = !mem_busy && ($urandom_range(99) < gnt_pct);
        if (mem_busy && mem_cnt == 0) begin
            imemValid = 1'b1; imemData = mem_data;
        end else if (!mem_busy && $urandom_range(99) < spur_pct) begin
            imemValid = 1'b1; imemData = $urandom;
        end else begin
            imemValid = 1'b0; imemData = $urandom;
        end
        #1;
        req_exp = !m_out && (m_held.size() == 0);
        vectors++;
        if (imemReq !== req_exp) begin
            miscompares++;
            $display("FAIL imemReq: got %b expected %b at %0t", imemReq, req_exp, $time);
        end
        if (req_exp) begin
            vectors++;
            if (imemAddr !== m_pc) begin
                miscompares++;
                $display("FAIL imemAddr: got %h expected %h at %0t", imemAddr, m_pc, $time);
            end
        end
        dut_accept = imemReq && imemGnt;
        @(posedge clk);
        model_edge(req_exp && imemGnt);
        mem_age();
        if (dut_accept) begin
            mem_busy = 1'b1;
            mem_cnt  = $urandom_range(lat_max - 1, lat_min - 1);
            mem_data = fixed_en ? fixed_data : $urandom;
        end
        @(negedge clk);
        vectors++;
        if (instValid !== m_valid || inst !== m_inst || instPc !== m_inst_pc) begin
            miscompares++;
            $display("FAIL inst_out: got v=%b inst=%h pc=%h expected v=%b inst=%h pc=%h at %0t",
                     instValid, inst, instPc, m_valid, m_inst, m_inst_pc, $time);
        end
`ifdef IF_PERF_CNT_EN
        vectors++;
        if (instCount !== m_count) begin
            miscompares++;
            $display("FAIL instCount: got %0d expected %0d at %0t", instCount, m_count, $time);
        end
`endif
    endtask

    // Entered and left at a negedge; reset is asserted between edges and spans one posedge.
    task automatic do_reset();
        imemGnt = 1'b0; imemValid = 1'b0; stall = 1'b0; flush = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (inst !== NOP || instPc !== RESET_PC || instValid !== 1'b0
            || imemReq !== 1'b1 || imemAddr !== RESET_PC) begin
            miscompares++;
            $display("FAIL reset_state: got inst=%h pc=%h v=%b req=%b addr=%h expected inst=%h pc=%h v=0 req=1 addr=%h",
                     inst, instPc, instValid, imemReq, imemAddr, NOP, RESET_PC, RESET_PC);
        end
        @(posedge clk);
        mem_age();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        do_reset();
        cycle(1'b0, 1'b0, '0);
    endtask

    task automatic test_first_fetch();
        lat_min = 1; lat_max = 1; gnt_pct = 100; spur_pct = 0;
        fixed_en = 1'b1; fixed_data = 32'h0010_0093;
        do_reset();
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        vectors++;
        if (inst !== 32'h0010_0093 || instPc !== 32'h0 || instValid !== 1'b1) begin
            miscompares++;
            $display("FAIL first_fetch: got inst=%h pc=%h v=%b expected inst=00100093 pc=0 v=1",
                     inst, instPc, instValid);
        end
        vectors++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h4) begin
            miscompares++;
            $display("FAIL second_addr: got req=%b addr=%h expected req=1 addr=4", imemReq, imemAddr);
        end
    endtask

    task automatic test_stall_hold();
        fixed_data = 32'h0020_8113;
        repeat (3) cycle(1'b1, 1'b0, '0);
        vectors++;
        if (inst !== 32'h0010_0093 || instValid !== 1'b1 || imemReq !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_freeze: got inst=%h v=%b req=%b expected inst=00100093 v=1 req=0",
                     inst, instValid, imemReq);
        end
        cycle(1'b0, 1'b0, '0);
        vectors++;
        if (inst !== 32'h0020_8113 || instPc !== 32'h4 || instValid !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_release: got inst=%h pc=%h v=%b expected inst=00208113 pc=4 v=1",
                     inst, instPc, instValid);
        end
    endtask

    task automatic test_flush_wait();
        lat_min = 2; lat_max = 2;
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 32'h0000_0102);
        cycle(1'b0, 1'b0, '0);
        vectors++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h0000_0100 || instValid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_wait: got req=%b addr=%h v=%b expected req=1 addr=00000100 v=0",
                     imemReq, imemAddr, instValid);
        end
    endtask

    task automatic test_flush_stall_hold();
        lat_min = 1; lat_max = 1;
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 32'h0000_0200);
        vectors++;
        if (instValid !== 1'b0 || inst !== NOP || imemReq !== 1'b1 || imemAddr !== 32'h0000_0200) begin
            miscompares++;
            $display("FAIL flush_hold: got v=%b inst=%h req=%b addr=%h expected v=0 inst=%h req=1 addr=00000200",
                     instValid, inst, imemReq, imemAddr, NOP);
        end
        repeat (4) cycle(1'b0, 1'b0, '0);
    endtask

    task automatic test_pc_wrap();
        do_reset();
        gnt_pct = 0;
        cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
        gnt_pct = 100;
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        vectors++;
        if (instPc !== 32'hFFFF_FFFC || instValid !== 1'b1 || imemAddr !== 32'h0) begin
            miscompares++;
            $display("FAIL pc_wrap: got instPc=%h v=%b addr=%h expected instPc=fffffffc v=1 addr=0",
                     instPc, instValid, imemAddr);
        end
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_counter();
        int seen;
        int i;
        seen = 0;
        fixed_en = 1'b0; lat_min = 1; lat_max = 1; gnt_pct = 100; spur_pct = 0;
        do_reset();
        for (i = 0; i < 400 && m_count != 32'd10; i++) begin
            cycle(1'b0, (i == 4 || i == 9), 32'h0000_1000 + 32'(i * 64));
            if (instValid === 1'b1) seen++;
        end
        vectors++;
        if (m_count != 32'd10 || instCount !== 32'(seen)) begin
            miscompares++;
            $display("FAIL counter: got instCount=%0d expected %0d delivered (model %0d after %0d cycles)",
                     instCount, seen, m_count, i);
        end
    endtask
`endif

    task automatic test_random();
        fixed_en = 1'b0; lat_min = 1; lat_max = 3; gnt_pct = 70; spur_pct = 20;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499) == 0) do_reset();
            cycle($urandom_range(99) < 30, $urandom_range(99) < 5, $urandom);
        end
    endtask

    initial begin
        rst_n = 1'b0; imemGnt = 1'b0; imemValid = 1'b0; imemData = '0;
        stall = 1'b0; flush = 1'b0; redirectPc = '0;
        model_reset();
        test_reset();
        test_first_fetch();
        test_stall_hold();
        test_flush_wait();
        test_flush_stall_hold();
        test_pc_wrap();
`ifdef IF_PERF_CNT_EN
        test_counter();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
